// File: rtl/bps_rx_gen.sv
// bps_rx_gen: UART receive bit-timing generator.
// Starts a frame on a start-edge pulse, raises one mid-bit sample strobe per
// bit with its index, checks the start bit and flags frame completion.
// Divisor, parity and stop-bit count are latched at the start of each frame.
// Optional feature: define BPS_RX_MAJORITY_EN for a 2-of-3 majority vote
// around the mid-bit point. The strobe then comes one cycle later.
module bps_rx_gen #(
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_en,
    input  logic             rxd,
    input  logic [DIV_W-1:0] div,
    input  logic             parity_en,
    input  logic             stop2,
    output logic             busy,
    output logic             rx_sel_data,
    output logic [3:0]       rx_num,
    output logic             rx_bit,
    output logic             frame_done,
    output logic             start_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] half;
    logic [3:0]       frame_len;

`ifdef BPS_RX_MAJORITY_EN
    logic             samp_early;
    logic             samp_mid;
`endif

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] sample_pt;
    logic             cnt_wrap;
    logic             start_ok;
    logic             bad_start;
    logic             frame_end;

    // Divisors below 4 would leave no room for the sample window.
    assign div_eff  = (div < DIV_MIN) ? DIV_MIN : div;
    assign cnt_wrap = (cnt == div_q - ONE);

`ifdef BPS_RX_MAJORITY_EN
    assign sample_pt = half + ONE;
`else
    assign sample_pt = half;
`endif

    // A start edge that arrives while a frame is reporting its end is
    // dropped. The edge detector is expected to present it again.
    assign start_ok  = rx_en && !frame_done && !start_err;
    assign bad_start = rx_sel_data && (rx_num == 4'd0) && rx_bit;
    assign frame_end = rx_sel_data && (rx_num == frame_len - 4'd1);

    // Frame sequencing: bit counter, strobe, bit index and status pulses.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments, so every branch
        // reads the values from before this edge regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_q       <= DIV_MIN;
            half        <= DIV_MIN >> 1;
            frame_len   <= 4'(DATA_BITS + 2);
            busy        <= 1'b0;
            rx_sel_data <= 1'b0;
            rx_num      <= 4'd0;
            frame_done  <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            rx_sel_data <= 1'b0;
            frame_done  <= 1'b0;
            start_err   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    rx_num <= 4'd0;
                    if (start_ok) begin
                        div_q     <= div_eff;
                        half      <= div_eff >> 1;
                        frame_len <= 4'(DATA_BITS + 2) + {3'b000, parity_en}
                                     + {3'b000, stop2};
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt_wrap ? '0 : cnt + ONE;
                    if (cnt == sample_pt) begin
                        rx_sel_data <= 1'b1;
                    end
                    if (bad_start) begin
                        start_err <= 1'b1;
                        busy      <= 1'b0;
                        rx_num    <= 4'd0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if (frame_end) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        rx_num     <= 4'd0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else if (rx_sel_data) begin
                        rx_num <= rx_num + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line sampling around the mid-bit point. rx_bit is updated on the same
    // edge that raises the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_bit <= 1'b1;
`ifdef BPS_RX_MAJORITY_EN
            samp_early <= 1'b1;
            samp_mid   <= 1'b1;
`endif
        end else if (state == RUN) begin
`ifdef BPS_RX_MAJORITY_EN
            if (cnt == half - ONE) begin
                samp_early <= rxd;
            end
            if (cnt == half) begin
                samp_mid <= rxd;
            end
            if (cnt == half + ONE) begin
                rx_bit <= (samp_early & samp_mid) | (samp_early & rxd)
                          | (samp_mid & rxd);
            end
`else
            if (cnt == half) begin
                rx_bit <= rxd;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bps_rx_gen.sv
// Self-checking bench for bps_rx_gen.
// Each test fills per-cycle stimulus tables. A frame-level reference model
// then derives per-cycle expected outputs from the timing rules: strobe k at
// start+LAT+half+k*div_q, the sampled line value, and termination and reset
// rules. The DUT outputs are compared against those expectations every cycle.
module tb_bps_rx_gen;

    localparam int DIV_W     = 16;
    localparam int DATA_BITS = 8;
    localparam int NMAX      = 4096;
`ifdef BPS_RX_MAJORITY_EN
    localparam int LAT = 3;
    localparam bit MAJ = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit MAJ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_en = 1'b0;
    logic             rxd = 1'b1;
    logic [DIV_W-1:0] div = DIV_W'(16);
    logic             parity_en = 1'b0;
    logic             stop2 = 1'b0;
    logic             busy;
    logic             rx_sel_data;
    logic [3:0]       rx_num;
    logic             rx_bit;
    logic             frame_done;
    logic             start_err;

    bps_rx_gen #(
        .DIV_W     (DIV_W),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .rxd         (rxd),
        .div         (div),
        .parity_en   (parity_en),
        .stop2       (stop2),
        .busy        (busy),
        .rx_sel_data (rx_sel_data),
        .rx_num      (rx_num),
        .rx_bit      (rx_bit),
        .frame_done  (frame_done),
        .start_err   (start_err)
    );

    always #5 clk = ~clk;

    // Per-cycle stimulus tables.
    bit s_rst [NMAX];
    bit s_en  [NMAX];
    bit s_rxd [NMAX];
    int s_div [NMAX];
    bit s_par [NMAX];
    bit s_s2  [NMAX];

    // Per-cycle expectations from the reference model.
    bit e_busy [NMAX];
    bit e_sel  [NMAX];
    int e_num  [NMAX];
    bit e_bit  [NMAX];
    bit e_done [NMAX];
    bit e_err  [NMAX];
    bit e_bset [NMAX];
    bit e_bval [NMAX];

    // Observations kept for targeted checks.
    bit o_bit [NMAX];
    bit o_sel [NMAX];
    int first_done;
    int first_err;
    int first_sel;
    int n_done;

    int n_cyc;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit line_at(input int c);
        if (c < 0 || c >= NMAX) return 1'b1;
        return s_rxd[c];
    endfunction

    // Value the receiver should report for a strobe at cycle sc.
    function automatic bit sampled(input int sc);
        bit a, b, d;
        a = line_at(sc - 3);
        b = line_at(sc - 2);
        d = line_at(sc - 1);
        if (MAJ) return (a & b) | (a & d) | (b & d);
        return d;
    endfunction

    task automatic new_test(input int n);
        n_cyc = n;
        for (int c = 0; c < NMAX; c++) begin
            s_rst[c] = (c == 0);
            s_en[c]  = 1'b0;
            s_rxd[c] = 1'b1;
            s_div[c] = int'($urandom_range(0, 200));
            s_par[c] = 1'($urandom_range(0, 1));
            s_s2[c]  = 1'($urandom_range(0, 1));
        end
    endtask

    // Writes one frame onto the line, LSB first with even parity.
    // A glitch inverts the line for one cycle. stop_c is the cycle where the
    // frame should report completion.
    task automatic put_frame(input int t0, input int dv, input bit par, input bit s2,
                             input int data, input int glitch_c, output int stop_c);
        int dq, flen;
        bit b, p;
        dq   = (dv < 4) ? 4 : dv;
        flen = 2 + DATA_BITS + int'(par) + int'(s2);
        s_en[t0]  = 1'b1;
        s_div[t0] = dv;
        s_par[t0] = par;
        s_s2[t0]  = s2;
        p = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) p ^= data[i];
        for (int k = 0; k < flen; k++) begin
            if (k == 0)                          b = 1'b0;
            else if (k <= DATA_BITS)             b = data[k-1];
            else if (par && k == DATA_BITS + 1)  b = p;
            else                                 b = 1'b1;
            for (int c = t0 + 1 + k * dq; c <= t0 + (k + 1) * dq; c++)
                if (c < NMAX) s_rxd[c] = b;
        end
        if (glitch_c >= 0 && glitch_c < NMAX) s_rxd[glitch_c] = ~s_rxd[glitch_c];
        stop_c = t0 + LAT + dq / 2 + (flen - 1) * dq + 1;
    endtask

    // Frame-level reference model.
    task automatic build_model();
        int t, cur;
        for (int c = 0; c < NMAX; c++) begin
            e_busy[c] = 0; e_sel[c] = 0; e_num[c] = 0;
            e_done[c] = 0; e_err[c] = 0; e_bset[c] = 0; e_bval[c] = 0;
        end
        t = 0;
        while (t < n_cyc) begin
            if (s_rst[t] || !s_en[t]) begin
                t++;
                continue;
            end
            begin
                int dq, h, flen, nat_stop, stop;
                bit bad, aborted;
                dq   = (s_div[t] < 4) ? 4 : s_div[t];
                h    = dq / 2;
                flen = 2 + DATA_BITS + int'(s_par[t]) + int'(s_s2[t]);
                bad  = sampled(t + LAT + h);
                nat_stop = bad ? t + LAT + h + 1 : t + LAT + h + (flen - 1) * dq + 1;
                stop    = nat_stop;
                aborted = 1'b0;
                for (int r = t + 1; r < nat_stop && r < NMAX; r++) begin
                    if (s_rst[r]) begin
                        stop    = r + 1;
                        aborted = 1'b1;
                        break;
                    end
                end
                for (int c = t + 1; c < stop && c < NMAX; c++) begin
                    int n;
                    e_busy[c] = 1'b1;
                    n = 0;
                    for (int k = 0; k < flen; k++)
                        if (t + LAT + h + k * dq < c) n++;
                    e_num[c] = n;
                end
                for (int k = 0; k < flen; k++) begin
                    int sc;
                    sc = t + LAT + h + k * dq;
                    if (sc < stop && sc < NMAX) begin
                        e_sel[sc]  = 1'b1;
                        e_bset[sc] = 1'b1;
                        e_bval[sc] = sampled(sc);
                    end
                end
                if (!aborted && stop < NMAX) begin
                    if (bad) e_err[stop] = 1'b1;
                    else     e_done[stop] = 1'b1;
                end
                t = aborted ? stop : stop + 1;
            end
        end
        cur = 1;
        for (int c = 0; c < NMAX; c++) begin
            if (c > 0 && s_rst[c-1]) cur = 1;
            if (e_bset[c]) cur = int'(e_bval[c]);
            e_bit[c] = 1'(cur);
        end
    endtask

    // Applies the stimulus table and compares every cycle against the model.
    task automatic run_stim(input string name);
        build_model();
        first_done = -1;
        first_err  = -1;
        first_sel  = -1;
        n_done     = 0;
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk);
            #1;
            rst       = s_rst[c];
            rx_en     = s_en[c];
            rxd       = s_rxd[c];
            div       = DIV_W'(s_div[c]);
            parity_en = s_par[c];
            stop2     = s_s2[c];
            @(negedge clk);
            o_bit[c] = rx_bit;
            o_sel[c] = rx_sel_data;
            if (c >= 1) begin
                if (frame_done) begin
                    n_done++;
                    if (first_done < 0) first_done = c;
                end
                if (start_err && first_err < 0) first_err = c;
                if (rx_sel_data && first_sel < 0) first_sel = c;
                check($sformatf("%s c%0d {busy,sel,num,bit,done,err}", name, c),
                      {23'd0, busy, rx_sel_data, rx_num, rx_bit, frame_done, start_err},
                      {23'd0, e_busy[c], e_sel[c], 4'(e_num[c]), e_bit[c], e_done[c], e_err[c]});
            end
        end
    endtask

    initial begin
        int stop_c, t;

        // Reset mid-frame, then a clean frame.
        new_test(300);
        put_frame(2, 16, 1'b0, 1'b0, int'($urandom), -1, stop_c);
        s_rst[62] = 1'b1;
        put_frame(100, 16, 1'b0, 1'b0, int'($urandom), -1, stop_c);
        run_stim("rst_mid");
        check("rst_mid first frame_done", 32'(first_done), 32'(100 + LAT + 8 + 144 + 1));

        // 8N1 at div 16.
        new_test(200);
        put_frame(2, 16, 1'b0, 1'b0, int'($urandom), -1, stop_c);
        run_stim("8n1");
        check("8n1 first strobe", 32'(first_sel), 32'(2 + LAT + 8));
        check("8n1 frame_done", 32'(first_done), 32'(2 + LAT + 8 + 144 + 1));

        // 8E2 at div 16.
        new_test(220);
        put_frame(2, 16, 1'b1, 1'b1, int'($urandom), -1, stop_c);
        run_stim("8e2");
        check("8e2 frame_done", 32'(first_done), 32'(2 + LAT + 8 + 176 + 1));

        // Runtime fields and rx_en ignored mid-frame; div 100 used next frame.
        new_test(1300);
        put_frame(2, 16, 1'b0, 1'b0, int'($urandom), -1, stop_c);
        s_en[52]  = 1'b1;
        s_div[52] = 100;
        put_frame(170, 100, 1'b0, 1'b0, int'($urandom), -1, stop_c);
        run_stim("ignore");
        check("ignore frame_done", 32'(first_done), 32'(2 + LAT + 8 + 144 + 1));
        check("ignore frames done", 32'(n_done), 32'd2);

        // div 2 is treated as 4.
        new_test(80);
        put_frame(2, 2, 1'b0, 1'b0, int'($urandom), -1, stop_c);
        run_stim("div2");
        check("div2 first strobe", 32'(first_sel), 32'(2 + LAT + 2));

        // False start: line back high before the mid-point.
        new_test(80);
        s_en[2]  = 1'b1;
        s_div[2] = 16;
        for (int c = 3; c <= 6; c++) s_rxd[c] = 1'b0;
        run_stim("false_start");
        check("false_start start_err", 32'(first_err), 32'(2 + LAT + 8 + 1));
        check("false_start no done", 32'(n_done), 32'd0);

        // Glitch on the bit with index 3 at its counter mid-point.
        new_test(200);
        put_frame(2, 16, 1'b0, 1'b0, int'($urandom) & ~32'h4, 2 + 1 + 8 + 48, stop_c);
        run_stim("glitch");
        check("glitch strobe", 32'(o_sel[2 + LAT + 56]), 32'd1);
        check("glitch rx_bit", 32'(o_bit[2 + LAT + 56]), MAJ ? 32'd0 : 32'd1);

        // Randomised back-to-back frames with line noise and resets.
        new_test(3800);
        t = 2;
        while (t < 3400) begin
            put_frame(t, int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom),
                      ($urandom_range(0, 3) == 0) ? t + int'($urandom_range(1, 200)) : -1,
                      stop_c);
            if ($urandom_range(0, 3) == 0) s_en[t + int'($urandom_range(5, 60))] = 1'b1;
            if ($urandom_range(0, 9) == 0) s_rst[t + int'($urandom_range(5, 80))] = 1'b1;
            t = stop_c + int'($urandom_range(0, 3));
        end
        run_stim("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
